// File: rtl/int2flt_pkg.sv
// int2flt_pkg: shared FSM state type and width helpers for the iterative int-to-float converter.
package int2flt_pkg;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int mag_w(input int int_w, input int twos_comp);
        return (twos_comp != 0) ? int_w : int_w - 1;
    endfunction

    // Working exponent must hold BIAS+MW plus a rounding carry and still compare against 2**EXP_W-1.
    function automatic int exp_reg_w(input int int_w, input int exp_w);
        int w;
        w = $clog2(bias(exp_w) + int_w + 1);
        return ((w > exp_w) ? w : exp_w) + 1;
    endfunction

endpackage

// File: rtl/flt_round_rne.sv
// flt_round_rne: combinational round-to-nearest-even of a truncated mantissa with exponent
// carry and saturation to infinity.
module flt_round_rne #(
    parameter int MAN_W = 10,
    parameter int EXP_W = 5,
    parameter int XW    = 6
) (
    input  logic [MAN_W-1:0] i_m,
    input  logic             i_g,
    input  logic             i_s,
    input  logic [XW-1:0]    i_exp,
    output logic [MAN_W-1:0] o_m,
    output logic [EXP_W-1:0] o_exp,
    output logic             o_ovf
);

    logic [MAN_W:0] w_sum;
    logic [XW-1:0]  w_exp;

    assign w_sum = {1'b0, i_m} + (MAN_W+1)'(i_g & (i_s | i_m[0]));
    // A carry out of the mantissa leaves its low bits zero, so only the exponent moves.
    assign w_exp = i_exp + XW'(w_sum[MAN_W]);
    assign o_ovf = w_exp >= XW'((1 << EXP_W) - 1);
    assign o_m   = o_ovf ? '0 : w_sum[MAN_W-1:0];
    assign o_exp = o_ovf ? '1 : w_exp[EXP_W-1:0];

endmodule

// File: rtl/int2flt_iter.sv
// int2flt_iter: multi-cycle integer to binary float converter; one left shift per NORM cycle,
// then a single RNE rounding cycle, with valid/ready on both sides.
module int2flt_iter
    import int2flt_pkg::*;
#(
    parameter int INT_W     = 16,
    parameter int EXP_W     = 5,
    parameter int MAN_W     = 10,
    parameter int TWOS_COMP = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INT_W-1:0]       int_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   flt_out,
    output logic                   overflow,
    output logic                   busy
);

    localparam int MW   = mag_w(INT_W, TWOS_COMP);
    localparam int BIAS = bias(EXP_W);
    localparam int XW   = exp_reg_w(INT_W, EXP_W);
    localparam int FW   = MW + MAN_W + 1;

    state_t               r_state, w_next;
    logic                 r_sign, r_ovf;
    logic [MW-1:0]        r_mag, w_mag_in;
    logic [XW-1:0]        r_exp;
    logic [EXP_W+MAN_W:0] r_flt;
    logic [INT_W-1:0]     w_abs;
    logic [FW-1:0]        w_frac;
    logic                 w_zero;
    logic [MAN_W-1:0]     w_m_rnd;
    logic [EXP_W-1:0]     w_exp_rnd;
    logic                 w_ovf;

    assign w_abs    = int_in[INT_W-1] ? -int_in : int_in;
    assign w_mag_in = (TWOS_COMP != 0) ? MW'(w_abs) : MW'(int_in[INT_W-2:0]);
    assign w_zero   = r_mag == '0;
    // Bits below the hidden one, padded so mantissa, guard and sticky always exist.
    assign w_frac   = {r_mag[MW-2:0], {(MAN_W+2){1'b0}}};

    flt_round_rne #(.MAN_W(MAN_W), .EXP_W(EXP_W), .XW(XW)) u_round (
        .i_m   (w_frac[FW-1 -: MAN_W]),
        .i_g   (w_frac[FW-1-MAN_W]),
        .i_s   (|w_frac[FW-2-MAN_W:0]),
        .i_exp (r_exp),
        .o_m   (w_m_rnd),
        .o_exp (w_exp_rnd),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = in_valid ? NORM : IDLE;
            NORM:    w_next = (w_zero || r_mag[MW-1]) ? ROUND : NORM;
            ROUND:   w_next = DONE;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sign <= 1'b0;
            r_mag  <= '0;
            r_exp  <= '0;
            r_flt  <= '0;
            r_ovf  <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_sign <= int_in[INT_W-1];
            r_mag  <= w_mag_in;
            r_exp  <= XW'(BIAS + MW - 1);
        end else if (r_state == NORM && !w_zero && !r_mag[MW-1]) begin
            r_mag  <= r_mag << 1;
            r_exp  <= r_exp - XW'(1);
        end else if (r_state == ROUND) begin
            r_flt  <= w_zero ? {r_sign, {(EXP_W+MAN_W){1'b0}}} : {r_sign, w_exp_rnd, w_m_rnd};
            r_ovf  <= !w_zero && w_ovf;
        end
    end

    assign in_ready  = r_state == IDLE;
    assign busy      = r_state != IDLE;
    assign out_valid = r_state == DONE;
    assign flt_out   = r_flt;
    assign overflow  = r_ovf;

endmodule
